// File: rtl/voter_pkg.sv
// Shared constants for the weighted voter tally: voter counts, weights and result width.
package voter_pkg;

    localparam int NP_W        = 32;
    localparam int VIP_W       = 8;
    localparam int VIP_WEIGHT  = 4;
    localparam int VVIP_WEIGHT = 16;
    localparam int RES_W       = 8;

    // Highest reachable tally once every voter has cast a vote.
    function automatic int max_tally();
        return NP_W + VIP_WEIGHT * VIP_W + VVIP_WEIGHT;
    endfunction

    localparam int MAX_TALLY = max_tally();

endpackage : voter_pkg

// File: rtl/voter_plus_popcount.sv
// Combinational population count of a W-bit vector, zero-extended to OUT_W bits.
module voter_plus_popcount #(
    parameter int W     = 32,
    parameter int OUT_W = 8
) (
    input  logic [W-1:0]     bits_i,
    output logic [OUT_W-1:0] count_o
);

    // NOTE: combinational logic uses blocking '=' and assigns a default before the loop,
    // so every path writes count_o and no latch is inferred.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < W; i++) begin
            count_o = count_o + OUT_W'(bits_i[i]);
        end
    end

endmodule : voter_plus_popcount

// File: rtl/voter_plus.sv
// Sticky one-vote-per-voter registers feeding a weighted tally of normal, VIP and VVIP votes.
module voter_plus
    import voter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NP_W-1:0]   np,
    input  logic [VIP_W-1:0]  vip,
    input  logic              vvip,
    output logic [RES_W-1:0]  result
);

    logic [NP_W-1:0]  np_q,   np_d;
    logic [VIP_W-1:0] vip_q,  vip_d;
    logic             vvip_q, vvip_d;

    logic [RES_W-1:0] np_cnt;
    logic [RES_W-1:0] vip_cnt;

    // A vote, once cast, is OR-ed in and can only be cleared by reset.
    always_comb begin
        np_d   = np_q   | np;
        vip_d  = vip_q  | vip;
        vvip_d = vvip_q | vvip;
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            np_q   <= '0;
            vip_q  <= '0;
            vvip_q <= 1'b0;
        end else begin
            np_q   <= np_d;
            vip_q  <= vip_d;
            vvip_q <= vvip_d;
        end
    end

    voter_plus_popcount #(
        .W     (NP_W),
        .OUT_W (RES_W)
    ) u_np_popcount (
        .bits_i  (np_q),
        .count_o (np_cnt)
    );

    voter_plus_popcount #(
        .W     (VIP_W),
        .OUT_W (RES_W)
    ) u_vip_popcount (
        .bits_i  (vip_q),
        .count_o (vip_cnt)
    );

    // Driven only from registered flags, so inputs never reach result within a cycle.
    always_comb begin
        result = np_cnt
               + RES_W'(VIP_WEIGHT) * vip_cnt
               + (vvip_q ? RES_W'(VVIP_WEIGHT) : RES_W'(0));
    end

endmodule : voter_plus

// File: tb/tb_voter_plus.sv
// Directed-vector bench for voter_plus with hand-computed expected tallies.
module tb_voter_plus;
    import voter_pkg::*;

    logic              clk;
    logic              reset;
    logic [NP_W-1:0]   np;
    logic [VIP_W-1:0]  vip;
    logic              vvip;
    logic [RES_W-1:0]  result;

    int n_vec;
    int n_err;

    voter_plus dut (
        .clk    (clk),
        .reset  (reset),
        .np     (np),
        .vip    (vip),
        .vvip   (vvip),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [RES_W-1:0] got,
                         input logic [RES_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: result=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive inputs away from the edge, let one rising edge sample them, then settle.
    task automatic apply(input logic [NP_W-1:0] np_v, input logic [VIP_W-1:0] vip_v,
                         input logic vvip_v);
        @(negedge clk);
        np   = np_v;
        vip  = vip_v;
        vvip = vvip_v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // Reset with arbitrary (all-ones) inputs across several edges.
        reset = 1'b1;
        np    = '1;
        vip   = '1;
        vvip  = 1'b1;
        #2;
        check("reset_initial", result, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_inputs_ignored", result, 8'd0);

        @(negedge clk);
        reset = 1'b0;
        np    = '0;
        vip   = '0;
        vvip  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("idle_after_reset_%0d", i), result, 8'd0);
        end

        // Accumulating votes across edges.
        apply(32'hF000_F000, 8'hFF, 1'b1);
        check("single_edge", result, 8'd56);
        apply(32'h0F00_0F00, 8'h00, 1'b0);
        check("retain_plus_new", result, 8'd64);
        apply(32'h00FF_00FF, 8'h00, 1'b0);
        check("full_tally", result, 8'd80);
        check("full_tally_pkg", result, RES_W'(MAX_TALLY));
        apply(32'hFFFF_FFFF, 8'hFF, 1'b1);
        check("no_double_count_0", result, 8'd80);
        apply(32'hFFFF_FFFF, 8'hFF, 1'b1);
        check("no_double_count_1", result, 8'd80);

        // Asynchronous reset between edges.
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_immediate", result, 8'd0);
        np   = '1;
        vip  = '1;
        vvip = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("held_in_reset_%0d", i), result, 8'd0);
        end

        @(negedge clk);
        reset = 1'b0;
        np    = '0;
        vip   = '0;
        vvip  = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_clear", result, 8'd0);

        // Weight isolation, one class at a time.
        apply(32'h0000_0000, 8'h01, 1'b0);
        check("vip_weight", result, 8'd4);
        apply(32'h0000_0000, 8'h00, 1'b1);
        check("vvip_weight", result, 8'd20);

        // A freshly driven vote must not show before the sampling edge.
        @(negedge clk);
        np   = 32'h8000_0000;
        vip  = '0;
        vvip = 1'b0;
        #1;
        check("no_comb_path", result, 8'd20);
        @(posedge clk);
        #1;
        check("np_weight", result, 8'd21);

        // Withdrawing the input keeps the vote.
        apply(32'h0000_0000, 8'h00, 1'b0);
        check("sticky_after_release", result, 8'd21);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_voter_plus

// File: doc/voter_plus.md
Name: voter_plus

Overview:
- Cumulative weighted vote tally with one-vote-per-voter semantics.
- 32 normal voters (weight 1), 8 VIP voters (weight 4) and 1 VVIP voter (weight 16) assert their input bits.
- A voter's vote is latched permanently once cast and cannot be withdrawn until reset.
- Outputs the running weighted total. Used as a standalone datapath block in the single-clock domain.

Parameters:
- NP_W, 32, number of normal voters (weight 1 each).
- VIP_W, 8, number of VIP voters (weight 4 each).
- VIP_WEIGHT, 4, vote weight of each VIP.
- VVIP_WEIGHT, 16, vote weight of the single VVIP.
- RES_W, 8, width of result; must hold NP_W + VIP_WEIGHT*VIP_W + VVIP_WEIGHT (80 at defaults).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset; clears all latched votes.
- np  input  32  normal voter bits; bit i = 1 means voter i casts a vote this cycle.
- vip  input  8  VIP voter bits; bit i = 1 means VIP i casts a vote this cycle.
- vvip  input  1  VVIP vote bit.
- result  output  8  weighted total of all latched votes.

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Internal state:
  - np_q[31:0], vip_q[7:0], vvip_q, one sticky flag per voter.
  - All flags are cleared to 0 immediately on reset assertion, independent of clk.
- Each rising clk edge with reset low: np_q <= np_q | np; vip_q <= vip_q | vip; vvip_q <= vvip_q | vvip.
- Once set, a flag stays 1 until reset. Deasserting an input bit never removes a vote.
- Asserting an already-latched bit again has no effect (no double counting).
- result = popcount(np_q) + 4*popcount(vip_q) + 16*vvip_q.
  - Combinational from the registered flags only; no combinational path from np/vip/vvip to result.
  - A vote is visible in result after the first rising edge at which it is sampled (1-cycle latency).
- Width rules:
  - Popcounts are zero-extended to RES_W before weighting and summing.
  - Maximum total is 32+32+16 = 80 < 256, so no overflow or saturation is possible at defaults.
- Reset value: result = 0, including reset asserted mid-operation.
  - result drops to 0 asynchronously while reset is high; inputs are ignored during reset.
- Reset deasserted coincident with a clk edge: that edge does not latch votes. Votes are latched from the first edge with reset low.
- Multiple voters in one cycle are all latched in that cycle; all bits are independent.
- X on inputs is not supported; inputs must be driven 0/1.

Decomposition:
- Shared package voter_pkg:
  - constants NP_W, VIP_W, VIP_WEIGHT, VVIP_WEIGHT, RES_W;
  - a function or constant for the maximum tally (80) for bench checks.
- One natural sub-module: popcount, parameterised by input width W and output width. It is instantiated twice, for np_q (W=32) and vip_q (W=8).
- Top level holds the sticky registers, the weighted adder and the reset logic.

Test Plan:
- Reset: assert reset with arbitrary inputs, then deassert with all inputs 0 for several edges -> result = 0 throughout.
- Single edge: np=32'hF000_F000, vip=8'hFF, vvip=1 for one edge -> result = 8+32+16 = 56 after that edge.
- Deassert and new votes: next edge np=32'h0F00_0F00, vip=0, vvip=0 -> result = 64 (earlier votes retained).
- Full tally: next edge np=32'h00FF_00FF -> result = 80 (all voters latched). Then hold np=32'hFFFF_FFFF, vip=8'hFF, vvip=1 -> result stays 80 (no double count).
- Async reset mid-operation: assert reset between clock edges while result = 80 -> result = 0 before the next edge. It stays 0 while reset is high, even with inputs at all ones.
- Weight isolation:
  - After reset, vip=8'h01 only -> result = 4.
  - Then vvip=1 only -> 20.
  - Then np=32'h8000_0000 only -> 21.
